axi_arbiter_n: RTL and testbench

AXI_ARBITER_N -- requirements
Module: axi_arbiter_n

---
 rtl/axi_arbiter_n.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_arbiter_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter_n.sv
// N-master to 1-slave AXI arbiter: one owner at a time, whole-transaction granularity.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module axi_arbiter_n #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  // Per-master read address
  input  logic [NUM_M*ADDR_W-1:0]     m_araddr,
  input  logic [NUM_M*8-1:0]          m_arlen,
  input  logic [NUM_M*3-1:0]          m_arsize,
  input  logic [NUM_M*2-1:0]          m_arburst,
  input  logic [NUM_M-1:0]            m_arvalid,
  output logic [NUM_M-1:0]            m_arready,
  // Per-master read data
  output logic [NUM_M*DATA_W-1:0]     m_rdata,
  output logic [NUM_M*2-1:0]          m_rresp,
  output logic [NUM_M-1:0]            m_rlast,
  output logic [NUM_M-1:0]            m_rvalid,
  input  logic [NUM_M-1:0]            m_rready,
  // Per-master write address
  input  logic [NUM_M*ADDR_W-1:0]     m_awaddr,
  input  logic [NUM_M*8-1:0]          m_awlen,
  input  logic [NUM_M*2-1:0]          m_awburst,
  input  logic [NUM_M-1:0]            m_awvalid,
  output logic [NUM_M-1:0]            m_awready,
  // Per-master write data
  input  logic [NUM_M*DATA_W-1:0]     m_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0] m_wstrb,
  input  logic [NUM_M-1:0]            m_wlast,
  input  logic [NUM_M-1:0]            m_wvalid,
  output logic [NUM_M-1:0]            m_wready,
  // Per-master write response
  output logic [NUM_M*2-1:0]          m_bresp,
  output logic [NUM_M-1:0]            m_bvalid,
  input  logic [NUM_M-1:0]            m_bready,
  // Slave side
  output logic [ADDR_W-1:0]           s_araddr,
  output logic [7:0]                  s_arlen,
  output logic [2:0]                  s_arsize,
  output logic [1:0]                  s_arburst,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  input  logic [DATA_W-1:0]           s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  output logic [ADDR_W-1:0]           s_awaddr,
  output logic [7:0]                  s_awlen,
  output logic [1:0]                  s_awburst,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_wstrb,
  output logic                        s_wlast,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  input  logic [1:0]                  s_bresp,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  // Status
  output logic [NUM_M-1:0]            grant,
  output logic                        len_err,
  output logic [1:0]                  o_dbg_state
);

  // Handshake rule on every channel: a transfer happens in a cycle where
  // valid and ready are both 1 at the rising edge; valid never waits on ready.

  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [NUM_M-1:0]   r_grant;
  logic [IDX_W-1:0]   r_owner, w_win_idx;
  logic               r_addr_done, r_len_err;
  logic [7:0]         r_beat, r_arlen;
  logic [NUM_M-1:0]   w_req;
  logic               w_any_req, w_ar_hs, w_aw_hs, w_r_hs, w_rd_end, w_wr_end, w_drop;

  assign w_req     = m_arvalid | m_awvalid;
  assign w_any_req = |w_req;

`ifdef AXI_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  always_comb begin : arb_rr
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    w_win_idx = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!found && w_req[idx]) begin
        found     = 1'b1;
        w_win_idx = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= IDX_W'(NUM_M - 1);
    else if (r_state == IDLE && w_any_req) r_ptr <= w_win_idx;
  end
`else
  always_comb begin : arb_fixed
    w_win_idx = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (w_req[k]) w_win_idx = IDX_W'(k);
    end
  end
`endif

  // Owner routing; the address channel closes after its handshake so one grant is one burst.
  always_comb begin
    m_arready = '0;  m_rdata  = '0;  m_rresp  = '0;  m_rlast = '0;  m_rvalid = '0;
    m_awready = '0;  m_wready = '0;  m_bresp  = '0;  m_bvalid = '0;
    s_araddr  = '0;  s_arlen  = '0;  s_arsize = '0;  s_arburst = '0; s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awaddr  = '0;  s_awlen  = '0;  s_awburst = '0; s_awvalid = 1'b0;
    s_wdata   = '0;  s_wstrb  = '0;  s_wlast  = 1'b0; s_wvalid = 1'b0;
    s_bready  = 1'b0;
    if (r_state == BUSY_RD) begin
      s_araddr  = m_araddr[int'(r_owner)*ADDR_W +: ADDR_W];
      s_arlen   = m_arlen[int'(r_owner)*8 +: 8];
      s_arsize  = m_arsize[int'(r_owner)*3 +: 3];
      s_arburst = m_arburst[int'(r_owner)*2 +: 2];
      s_arvalid = m_arvalid[r_owner] & ~r_addr_done;
      m_arready[r_owner] = s_arready & ~r_addr_done;
      m_rdata[int'(r_owner)*DATA_W +: DATA_W] = s_rdata;
      m_rresp[int'(r_owner)*2 +: 2]           = s_rresp;
      m_rlast[r_owner]  = s_rlast;
      m_rvalid[r_owner] = s_rvalid;
      s_rready          = m_rready[r_owner];
    end
    if (r_state == BUSY_WR) begin
      s_awaddr  = m_awaddr[int'(r_owner)*ADDR_W +: ADDR_W];
      s_awlen   = m_awlen[int'(r_owner)*8 +: 8];
      s_awburst = m_awburst[int'(r_owner)*2 +: 2];
      s_awvalid = m_awvalid[r_owner] & ~r_addr_done;
      m_awready[r_owner] = s_awready & ~r_addr_done;
      s_wdata   = m_wdata[int'(r_owner)*DATA_W +: DATA_W];
      s_wstrb   = m_wstrb[int'(r_owner)*STRB_W +: STRB_W];
      s_wlast   = m_wlast[r_owner];
      s_wvalid  = m_wvalid[r_owner];
      m_wready[r_owner] = s_wready;
      m_bresp[int'(r_owner)*2 +: 2] = s_bresp;
      m_bvalid[r_owner] = s_bvalid;
      s_bready          = m_bready[r_owner];
    end
  end

  assign w_ar_hs  = s_arvalid & s_arready;
  assign w_aw_hs  = s_awvalid & s_awready;
  assign w_r_hs   = s_rvalid & s_rready;
  assign w_rd_end = w_r_hs & s_rlast;
  assign w_wr_end = s_bvalid & s_bready;
  // An owner that withdraws its request before the address handshake forfeits the grant.
  assign w_drop   = ~r_addr_done &
                    (((r_state == BUSY_RD) & ~m_arvalid[r_owner]) |
                     ((r_state == BUSY_WR) & ~m_awvalid[r_owner]));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = m_arvalid[w_win_idx] ? BUSY_RD : BUSY_WR;
      BUSY_RD: if (w_rd_end || w_drop) w_next = IDLE;
      BUSY_WR: if (w_wr_end || w_drop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_addr_done <= 1'b0;
      r_beat      <= '0;
      r_arlen     <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_len_err <= 1'b0;
      if (r_state == IDLE && w_any_req) begin
        r_grant     <= NUM_M'(1) << w_win_idx;
        r_owner     <= w_win_idx;
        r_addr_done <= 1'b0;
      end else if (w_next == IDLE) begin
        r_grant     <= '0;
        r_addr_done <= 1'b0;
      end else if (w_ar_hs || w_aw_hs) begin
        r_addr_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_beat  <= '0;
        r_arlen <= s_arlen;
      end else if (w_r_hs) begin
        r_beat    <= r_beat + 8'd1;
        r_len_err <= (s_rlast && (r_beat != r_arlen)) || (r_beat > r_arlen);
      end
    end
  end

  assign grant       = r_grant;
  assign len_err     = r_len_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_arbiter_n.sv
// Directed bench for axi_arbiter_n with four masters; the bench drives the slave side itself.
module tb_axi_arbiter_n;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NM*AW-1:0]     m_araddr = '0, m_awaddr = '0;
  logic [NM*8-1:0]      m_arlen = '0, m_awlen = '0;
  logic [NM*3-1:0]      m_arsize = '0;
  logic [NM*2-1:0]      m_arburst = '0, m_awburst = '0;
  logic [NM-1:0]        m_arvalid = '0, m_rready = '0, m_awvalid = '0;
  logic [NM-1:0]        m_wlast = '0, m_wvalid = '0, m_bready = '0;
  logic [NM*DW-1:0]     m_wdata = '0;
  logic [NM*(DW/8)-1:0] m_wstrb = '0;
  logic [NM-1:0]        m_arready, m_rlast, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [NM*DW-1:0]     m_rdata;
  logic [NM*2-1:0]      m_rresp, m_bresp;

  logic [AW-1:0]   s_araddr, s_awaddr;
  logic [7:0]      s_arlen, s_awlen;
  logic [2:0]      s_arsize;
  logic [1:0]      s_arburst, s_awburst;
  logic            s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_arready = 1'b1, s_awready = 1'b1, s_wready = 1'b1;
  logic [DW-1:0]   s_rdata = '0;
  logic [1:0]      s_rresp = '0, s_bresp = '0;
  logic            s_rlast = 1'b0, s_rvalid = 1'b0, s_bvalid = 1'b0;

  logic [NM-1:0] grant;
  logic          len_err;
  logic [1:0]    o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_seq[5];

  axi_arbiter_n #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .len_err(len_err), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_grant",   64'(grant), 64'd0);
    chk("reset_state",   64'(o_dbg_state), 64'd0);
    chk("reset_len_err", 64'(len_err), 64'd0);
    chk("reset_arvalid", 64'(s_arvalid), 64'd0);

    // Master 0 reads 4 beats
    m_araddr[31:0] = 32'h0000_1000;
    m_arlen[7:0]   = 8'd3;
    m_arvalid      = 4'b0001;
    m_rready       = 4'b1111;
    #1;
    chk("idle_no_fwd_arvalid", 64'(s_arvalid), 64'd0);
    chk("idle_no_arready",     64'(m_arready), 64'd0);
    tick();
    chk("rd_grant",   64'(grant), 64'h1);
    chk("rd_state",   64'(o_dbg_state), 64'd1);
    chk("rd_arvalid", 64'(s_arvalid), 64'd1);
    chk("rd_araddr",  64'(s_araddr), 64'h1000);
    chk("rd_arlen",   64'(s_arlen), 64'd3);
    chk("rd_arready", 64'(m_arready), 64'h1);
    tick();
    m_arvalid = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1;
      s_rdata  = 64'hA0 + 64'(b);
      s_rlast  = (b == 3);
      #1;
      chk("rd_rvalid",       64'(m_rvalid), 64'h1);
      chk("rd_rdata",        m_rdata[63:0], 64'hA0 + 64'(b));
      chk("rd_rdata_others", 64'(|m_rdata[NM*DW-1:DW]), 64'd0);
      tick();
      chk("rd_len_err", 64'(len_err), 64'd0);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    chk("rd_end_state", 64'(o_dbg_state), 64'd0);
    chk("rd_end_grant", 64'(grant), 64'd0);

    // Short burst: rlast on the third beat of an arlen=3 read
    m_arvalid = 4'b0001;
    tick();
    tick();
    m_arvalid = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1;
      tick();
      chk("short_no_err", 64'(len_err), 64'd0);
    end
    s_rlast = 1'b1;
    tick();
    chk("short_len_err", 64'(len_err), 64'd1);
    chk("short_state",   64'(o_dbg_state), 64'd0);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    tick();
    chk("short_len_err_clr", 64'(len_err), 64'd0);

    // Master 1 single-beat write
    m_awaddr[63:32]  = 32'h0000_2000;
    m_awlen[15:8]    = 8'd0;
    m_wdata[127:64]  = 64'h1122_3344_5566_7788;
    m_wstrb[15:8]    = 8'hFF;
    m_wlast[1]       = 1'b1;
    m_wvalid         = 4'b0010;
    m_awvalid        = 4'b0010;
    m_bready         = 4'b0011;
    tick();
    chk("wr_grant",    64'(grant), 64'h2);
    chk("wr_state",    64'(o_dbg_state), 64'd2);
    chk("wr_awvalid",  64'(s_awvalid), 64'd1);
    chk("wr_awaddr",   64'(s_awaddr), 64'h2000);
    chk("wr_wdata",    s_wdata, 64'h1122_3344_5566_7788);
    chk("wr_wstrb",    64'(s_wstrb), 64'hFF);
    chk("wr_wvalid",   64'(s_wvalid), 64'd1);
    chk("wr_awready",  64'(m_awready), 64'h2);
    chk("wr_wready",   64'(m_wready), 64'h2);
    chk("wr_arvalid",  64'(s_arvalid), 64'd0);
    chk("wr_m0_quiet", 64'({m_arready[0], m_awready[0], m_wready[0], m_rvalid[0], m_bvalid[0]}), 64'd0);
    tick();
    m_awvalid = 4'b0000;
    m_wvalid  = 4'b0000;
    s_bvalid  = 1'b1;
    s_bresp   = 2'b00;
    #1;
    chk("wr_bvalid", 64'(m_bvalid), 64'h2);
    chk("wr_bresp",  64'(m_bresp), 64'd0);
    chk("wr_bready", 64'(s_bready), 64'd1);
    tick();
    s_bvalid = 1'b0;
    chk("wr_end_state", 64'(o_dbg_state), 64'd0);
    chk("wr_end_grant", 64'(grant), 64'd0);

    // Request withdrawn before the address handshake
    s_arready = 1'b0;
    m_arvalid = 4'b0100;
    tick();
    chk("drop_grant", 64'(grant), 64'h4);
    m_arvalid = 4'b0000;
    tick();
    chk("drop_state", 64'(o_dbg_state), 64'd0);
    chk("drop_grant_clr", 64'(grant), 64'd0);
    s_arready = 1'b1;

    // All four masters requesting continuously
    do_reset();
`ifdef AXI_ARB_RR_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    m_arlen   = '0;
    m_arvalid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("arb_grant",   64'(grant), 64'(1) << exp_seq[t]);
      chk("arb_arvalid", 64'(s_arvalid), 64'd1);
      tick();
      s_rvalid = 1'b1;
      s_rlast  = 1'b1;
      #1;
      chk("arb_rvalid", 64'(m_rvalid), 64'(1) << exp_seq[t]);
      tick();
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      chk("arb_gap_grant",   64'(grant), 64'd0);
      chk("arb_gap_arvalid", 64'(s_arvalid), 64'd0);
    end
    m_arvalid = 4'b0000;
    tick();

    // Reset during the third beat of a 4-beat read by master 1
    m_arlen[15:8] = 8'd3;
    m_arvalid     = 4'b0010;
    tick();
    tick();
    m_arvalid = 4'b0000;
    s_rvalid  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_grant",   64'(grant), 64'd0);
    chk("rst_state",   64'(o_dbg_state), 64'd0);
    chk("rst_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_rready",  64'(s_rready), 64'd0);
    chk("rst_rvalid",  64'(m_rvalid), 64'd0);
    chk("rst_arready", 64'(m_arready), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    rst       = 1'b0;
    s_rvalid  = 1'b0;
    m_arvalid = 4'b1011;
    tick();
    chk("rst_next_winner", 64'(grant), 64'h1);
    m_arvalid = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
